// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard detector: tracks E/M writers, raises stall, bubbles E.
// Optional multiply/divide busy interlock enabled by macro HAZARD_MD_STALL_EN.
module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instr,
    input  logic [4:0]  D_T_use_rs,
    input  logic [4:0]  D_T_use_rt,
    output logic        stall,
    output logic        pc_en,
    output logic        if_d_en,
    output logic        d_e_clr,
    output logic [4:0]  E_dst,
    output logic [1:0]  E_T_new,
    output logic [4:0]  M_dst,
    output logic [1:0]  M_T_new,
    output logic        md_busy
);
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_shamt_unused;

    assign w_op           = D_instr[31:26];
    assign w_rs           = D_instr[25:21];
    assign w_rt           = D_instr[20:16];
    assign w_rd           = D_instr[15:11];
    assign w_funct        = D_instr[5:0];
    assign w_shamt_unused = ^D_instr[10:6];

    logic [4:0] r_e_dst;
    logic [1:0] r_e_tnew;
    logic [4:0] r_m_dst;
    logic [1:0] r_m_tnew;

    logic [4:0] w_d_dst;
    logic [1:0] w_d_tnew;

    always_comb begin
        w_d_dst  = '0;
        w_d_tnew = '0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        w_d_dst  = w_rd;
                        w_d_tnew = 2'd1;
                    end
                    6'h09:   w_d_dst = w_rd;
                    default: ;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                w_d_dst  = w_rt;
                w_d_tnew = 2'd1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_d_dst  = w_rt;
                w_d_tnew = 2'd2;
            end
            6'h03:   w_d_dst = 5'd31;
            default: ;
        endcase
    end

    // A zero source register never matches, so $0 writers in E/M are ignored.
    logic w_rs_hazard;
    logic w_rt_hazard;
    logic w_md_hazard;

    assign w_rs_hazard = (w_rs != '0) && (D_T_use_rs != 5'd31) &&
        (((w_rs == r_e_dst) && ({3'b000, r_e_tnew} > D_T_use_rs)) ||
         ((w_rs == r_m_dst) && ({3'b000, r_m_tnew} > D_T_use_rs)));
    assign w_rt_hazard = (w_rt != '0) && (D_T_use_rt != 5'd31) &&
        (((w_rt == r_e_dst) && ({3'b000, r_e_tnew} > D_T_use_rt)) ||
         ((w_rt == r_m_dst) && ({3'b000, r_m_tnew} > D_T_use_rt)));

    assign stall   = w_rs_hazard | w_rt_hazard | w_md_hazard;
    assign pc_en   = ~stall;
    assign if_d_en = ~stall;
    assign d_e_clr = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_dst  <= '0;
            r_e_tnew <= '0;
            r_m_dst  <= '0;
            r_m_tnew <= '0;
        end else begin
            if (stall) begin
                r_e_dst  <= '0;
                r_e_tnew <= '0;
            end else begin
                r_e_dst  <= w_d_dst;
                r_e_tnew <= w_d_tnew;
            end
            r_m_dst  <= r_e_dst;
            r_m_tnew <= (r_e_tnew == '0) ? '0 : r_e_tnew - 2'd1;
        end
    end

    assign E_dst   = r_e_dst;
    assign E_T_new = r_e_tnew;
    assign M_dst   = r_m_dst;
    assign M_T_new = r_m_tnew;

`ifdef HAZARD_MD_STALL_EN
    logic [3:0] r_md_cnt;
    logic [3:0] w_md_load;
    logic       w_md_op;

    always_comb begin
        w_md_load = '0;
        w_md_op   = 1'b0;
        if (w_op == 6'h00) begin
            case (w_funct)
                6'h18, 6'h19: begin
                    w_md_load = 4'd5;
                    w_md_op   = 1'b1;
                end
                6'h1a, 6'h1b: begin
                    w_md_load = 4'd10;
                    w_md_op   = 1'b1;
                end
                6'h10, 6'h11, 6'h12, 6'h13: w_md_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_md_hazard = w_md_op && (r_md_cnt != '0);
    assign md_busy     = (r_md_cnt != '0);

    // A stalled md op cannot load; it only loads on the edge it leaves D.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (!stall && (w_md_load != '0)) begin
            r_md_cnt <= w_md_load;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end
`else
    assign w_md_hazard = 1'b0;
    assign md_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: issue-history model plus directed scenarios.
// Expectations follow macro HAZARD_MD_STALL_EN when the bench is built with it.
module tb_hazard_stall_ctrl;
`ifdef HAZARD_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] D_instr;
    logic [4:0]  D_T_use_rs;
    logic [4:0]  D_T_use_rt;
    logic        stall;
    logic        pc_en;
    logic        if_d_en;
    logic        d_e_clr;
    logic [4:0]  E_dst;
    logic [1:0]  E_T_new;
    logic [4:0]  M_dst;
    logic [1:0]  M_T_new;
    logic        md_busy;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_instr    (D_instr),
        .D_T_use_rs (D_T_use_rs),
        .D_T_use_rt (D_T_use_rt),
        .stall      (stall),
        .pc_en      (pc_en),
        .if_d_en    (if_d_en),
        .d_e_clr    (d_e_clr),
        .E_dst      (E_dst),
        .E_T_new    (E_T_new),
        .M_dst      (M_dst),
        .M_T_new    (M_T_new),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t);
        return {op, s, t, 16'h0004};
    endfunction

    // Reference decode: what register an instruction writes and how many
    // stages after E its result becomes available.
    function automatic void tb_dec(input logic [31:0] w, output logic [4:0] d, output int t);
        logic [5:0] op;
        logic [5:0] f;
        op = w[31:26];
        f  = w[5:0];
        d  = 5'd0;
        t  = 0;
        if (op == 6'h00 && f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                                     6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                     6'h27, 6'h2a, 6'h2b}) begin
            d = w[15:11];
            t = 1;
        end else if (op == 6'h00 && f == 6'h09) begin
            d = w[15:11];
        end else if (op inside {[6'h08:6'h0f]}) begin
            d = w[20:16];
            t = 1;
        end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            d = w[20:16];
            t = 2;
        end else if (op == 6'h03) begin
            d = 5'd31;
        end
    endfunction

    function automatic bit tb_is_md(input logic [31:0] w);
        logic [5:0] f;
        f = w[5:0];
        return (w[31:26] == 6'h00) &&
               (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
    endfunction

    function automatic int tb_md_lat(input logic [31:0] w);
        logic [5:0] f;
        f = w[5:0];
        if (w[31:26] != 6'h00) return 0;
        if (f == 6'h18 || f == 6'h19) return 5;
        if (f == 6'h1a || f == 6'h1b) return 10;
        return 0;
    endfunction

    // Model: h_*[k] is what entered E on the k-th edge since reset (bubble = 0).
    // E holds entry n, M holds entry n-1 aged by one stage.
    int         n;
    logic [4:0] h_dst [0:4095];
    int         h_tn  [0:4095];
    int         md_issue;
    int         md_lat;

    function automatic logic [4:0] m_edst();
        return h_dst[n];
    endfunction
    function automatic int m_etn();
        return h_tn[n];
    endfunction
    function automatic logic [4:0] m_mdst();
        return (n > 0) ? h_dst[n-1] : 5'd0;
    endfunction
    function automatic int m_mtn();
        return (n > 0 && h_tn[n-1] > 0) ? h_tn[n-1] - 1 : 0;
    endfunction
    function automatic bit m_busy();
        return (md_lat != 0) && ((n - md_issue) < md_lat);
    endfunction
    function automatic bit m_haz(input logic [4:0] r, input logic [4:0] tuse);
        return (r != 5'd0) && (tuse != 5'd31) &&
               ((r == m_edst() && m_etn() > int'(tuse)) ||
                (r == m_mdst() && m_mtn() > int'(tuse)));
    endfunction
    function automatic bit m_stall();
        return m_haz(D_instr[25:21], D_T_use_rs) || m_haz(D_instr[20:16], D_T_use_rt) ||
               (MD_EN && tb_is_md(D_instr) && m_busy());
    endfunction

    logic [4:0] nd;
    int         nt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n        <= 0;
            h_dst[0] <= 5'd0;
            h_tn[0]  <= 0;
            md_issue <= 0;
            md_lat   <= 0;
        end else begin
            tb_dec(D_instr, nd, nt);
            if (m_stall()) begin
                h_dst[n+1] <= 5'd0;
                h_tn[n+1]  <= 0;
            end else begin
                h_dst[n+1] <= nd;
                h_tn[n+1]  <= nt;
                if (MD_EN && tb_md_lat(D_instr) != 0) begin
                    md_issue <= n + 1;
                    md_lat   <= tb_md_lat(D_instr);
                end
            end
            n <= n + 1;
        end
    end

    bit cmp_stall;
    always @(negedge clk) begin
        if (reset) begin
            cmp_stall = m_stall();
            chk("cmp_stall",   int'(stall),   int'(cmp_stall));
            chk("cmp_pc_en",   int'(pc_en),   int'(!cmp_stall));
            chk("cmp_if_d_en", int'(if_d_en), int'(!cmp_stall));
            chk("cmp_d_e_clr", int'(d_e_clr), int'(cmp_stall));
            chk("cmp_E_dst",   int'(E_dst),   int'(m_edst()));
            chk("cmp_E_T_new", int'(E_T_new), m_etn());
            chk("cmp_M_dst",   int'(M_dst),   int'(m_mdst()));
            chk("cmp_M_T_new", int'(M_T_new), m_mtn());
            chk("cmp_md_busy", int'(md_busy), int'(MD_EN && m_busy()));
        end
    end

    task automatic drv(input logic [31:0] w, input logic [4:0] ur, input logic [4:0] ut);
        @(posedge clk);
        #1;
        D_instr    = w;
        D_T_use_rs = ur;
        D_T_use_rt = ut;
    endtask

    task automatic issue(input logic [31:0] w, input logic [4:0] ur, input logic [4:0] ut);
        drv(w, ur, ut);
        for (int g = 0; g < 30; g++) begin
            @(negedge clk);
            if (!stall) break;
        end
        chk("issue_advance", int'(stall), 0);
    endtask

    logic [31:0] NOP;
    logic [31:0] JAL;
    int          scnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        NOP        = 32'h0;
        JAL        = {6'h03, 26'h0000100};
        reset      = 1'b0;
        D_instr    = itype(6'h04, 5'd8, 5'd9);
        D_T_use_rs = 5'd0;
        D_T_use_rt = 5'd0;

        #12;
        chk("rst_E_dst",   int'(E_dst),   0);
        chk("rst_E_T_new", int'(E_T_new), 0);
        chk("rst_M_dst",   int'(M_dst),   0);
        chk("rst_M_T_new", int'(M_T_new), 0);
        chk("rst_md_busy", int'(md_busy), 0);
        chk("rst_stall",   int'(stall),   0);
        #5;
        D_instr    = NOP;
        D_T_use_rs = 5'd31;
        D_T_use_rt = 5'd31;
        reset      = 1'b1;

        // lw $8 then beq $8,$9: two stall cycles, released on the third
        drv(itype(6'h23, 5'd0, 5'd8), 5'd1, 5'd31);
        @(negedge clk);
        chk("lw_alone_stall", int'(stall), 0);
        drv(itype(6'h04, 5'd8, 5'd9), 5'd0, 5'd0);
        @(negedge clk);
        chk("lwuse_c1_stall",   int'(stall),   1);
        chk("lwuse_c1_declr",   int'(d_e_clr), 1);
        chk("lwuse_c1_pc_en",   int'(pc_en),   0);
        chk("lwuse_c1_E_dst",   int'(E_dst),   8);
        chk("lwuse_c1_E_T_new", int'(E_T_new), 2);
        @(negedge clk);
        chk("lwuse_c2_stall",   int'(stall),   1);
        chk("lwuse_c2_declr",   int'(d_e_clr), 1);
        chk("lwuse_c2_E_dst",   int'(E_dst),   0);
        chk("lwuse_c2_M_dst",   int'(M_dst),   8);
        chk("lwuse_c2_M_T_new", int'(M_T_new), 1);
        @(negedge clk);
        chk("lwuse_c3_stall",   int'(stall),   0);
        chk("lwuse_c3_declr",   int'(d_e_clr), 0);
        chk("lwuse_c3_M_T_new", int'(M_T_new), 0);

        // addu $3 in E: ALU consumer does not stall, branch consumer stalls once
        drv(rtype(6'h21, 5'd1, 5'd2, 5'd3), 5'd1, 5'd1);
        drv(rtype(6'h21, 5'd3, 5'd5, 5'd4), 5'd1, 5'd1);
        @(negedge clk);
        chk("alu_alu_stall", int'(stall), 0);
        drv(rtype(6'h21, 5'd1, 5'd2, 5'd3), 5'd1, 5'd1);
        drv(itype(6'h04, 5'd9, 5'd3), 5'd0, 5'd0);
        @(negedge clk);
        chk("alu_br_c1_stall", int'(stall), 1);
        @(negedge clk);
        chk("alu_br_c2_stall", int'(stall), 0);
        chk("alu_br_c2_M_dst", int'(M_dst), 3);

        // load to $0 never creates a hazard
        drv(itype(6'h23, 5'd0, 5'd0), 5'd1, 5'd31);
        drv(itype(6'h04, 5'd0, 5'd0), 5'd0, 5'd0);
        @(negedge clk);
        chk("zero_dst_stall", int'(stall), 0);
        chk("zero_dst_E_dst", int'(E_dst), 0);

        // jal then jr $31: result ready immediately
        drv(JAL, 5'd31, 5'd31);
        drv(rtype(6'h08, 5'd31, 5'd0, 5'd0), 5'd0, 5'd31);
        @(negedge clk);
        chk("jal_jr_stall",   int'(stall),   0);
        chk("jal_E_dst",      int'(E_dst),   31);
        chk("jal_E_T_new",    int'(E_T_new), 0);

        // div then mflo
        drv(NOP, 5'd31, 5'd31);
        drv(rtype(6'h1a, 5'd1, 5'd2, 5'd0), 5'd1, 5'd1);
        drv(rtype(6'h12, 5'd0, 5'd0, 5'd7), 5'd31, 5'd31);
        scnt = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (!stall) break;
            scnt++;
        end
        chk("div_mflo_stall_cycles", scnt, MD_EN ? 10 : 0);
        chk("div_mflo_busy_after", int'(md_busy), 0);
        @(posedge clk);
        #1;
        chk("mflo_advanced_E_dst", int'(E_dst), 7);

        // async reset between edges with lw $8 in E and the md counter at 7
        drv(rtype(6'h1a, 5'd1, 5'd2, 5'd0), 5'd1, 5'd1);
        drv(NOP, 5'd31, 5'd31);
        drv(NOP, 5'd31, 5'd31);
        drv(itype(6'h23, 5'd0, 5'd8), 5'd1, 5'd31);
        drv(NOP, 5'd31, 5'd31);
        chk("pre_rst_E_dst",   int'(E_dst),   8);
        chk("pre_rst_md_busy", int'(md_busy), int'(MD_EN));
        #2;
        reset      = 1'b0;
        D_instr    = itype(6'h04, 5'd8, 5'd9);
        D_T_use_rs = 5'd0;
        D_T_use_rt = 5'd0;
        #1;
        chk("async_rst_E_dst",   int'(E_dst),   0);
        chk("async_rst_M_dst",   int'(M_dst),   0);
        chk("async_rst_E_T_new", int'(E_T_new), 0);
        chk("async_rst_md_busy", int'(md_busy), 0);
        chk("async_rst_stall",   int'(stall),   0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_E_dst", int'(E_dst), 0);
        chk("post_rst_M_dst", int'(M_dst), 0);

        // mixed program, checked every cycle against the model
        issue(itype(6'h09, 5'd0, 5'd8),          5'd1,  5'd31);
        issue(itype(6'h23, 5'd8, 5'd9),          5'd1,  5'd31);
        issue(rtype(6'h21, 5'd9, 5'd8, 5'd10),   5'd1,  5'd1);
        issue(rtype(6'h00, 5'd0, 5'd10, 5'd11),  5'd31, 5'd1);
        issue(itype(6'h04, 5'd11, 5'd10),        5'd0,  5'd0);
        issue(JAL,                               5'd31, 5'd31);
        issue(rtype(6'h09, 5'd31, 5'd0, 5'd5),   5'd0,  5'd31);
        issue(itype(6'h0f, 5'd0, 5'd12),         5'd31, 5'd31);
        issue(itype(6'h2b, 5'd9, 5'd12),         5'd1,  5'd2);
        issue(rtype(6'h18, 5'd12, 5'd9, 5'd0),   5'd1,  5'd1);
        issue(rtype(6'h10, 5'd0, 5'd0, 5'd13),   5'd31, 5'd31);
        issue(itype(6'h20, 5'd13, 5'd14),        5'd1,  5'd31);
        issue(itype(6'h04, 5'd14, 5'd0),         5'd0,  5'd0);
        issue(NOP,                               5'd31, 5'd31);
        issue(rtype(6'h1b, 5'd14, 5'd13, 5'd0),  5'd1,  5'd1);
        issue(rtype(6'h13, 5'd3, 5'd0, 5'd0),    5'd1,  5'd31);
        issue(itype(6'h25, 5'd0, 5'd2),          5'd1,  5'd31);
        issue(itype(6'h05, 5'd2, 5'd2),          5'd0,  5'd0);
        issue(rtype(6'h2a, 5'd2, 5'd8, 5'd2),    5'd1,  5'd1);
        issue(NOP,                               5'd31, 5'd31);
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
